fetch_unit_rv: RTL and testbench
================================

# fetch_unit_rv

Parametrised instruction-fetch unit for the multicycle RISC-V datapath. It owns the program counter, issues one read request at a time to instruction memory over a valid handshake, and captures the returned word into an instruction register with decoded fields. It stalls on downstream back-pressure and accepts a branch/jump redirect that may arrive while a read is still in flight.

## Interface
- XLEN, 64: width of PC and memory address.
- ILEN, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset; must be 4-byte aligned.
- CLK  in  1: clock; all state updates on the rising edge.
- RST  in  1: synchronous, active-high reset.
- mem_rreq  out  1: one-cycle read request pulse.
- mem_raddr  out  XLEN: read address; always equals the PC register.
- mem_rvalid  in  1: memory response strobe, arriving at least 1 cycle after mem_rreq.
- mem_rdata  in  ILEN: response data, valid when mem_rvalid=1.
- redir_valid  in  1: load a new PC.
- redir_pc  in  XLEN: redirect target.
- instr_valid  out  1: instruction register holds a deliverable instruction.
- instr_ready  in  1: downstream accepts the instruction.
- instr  out  ILEN: instruction register.
- instr_pc  out  XLEN: PC of `instr`.
- opcode  out  7: instr[6:0].
- rd  out  5: instr[11:7].
- rs1  out  5: instr[19:15].
- rs2  out  5: instr[24:20].
- fetch_count  out  XLEN: number of accepted instructions.
- fault  out  1: misaligned redirect seen; exists only with the macro set.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN, plus FAULT with the macro set.
- **IDLE:** no request; go to REQ.
- **REQ:** mem_rreq=1, mem_raddr=pc; go to WAIT.
- **WAIT:** wait for mem_rvalid.
  - On mem_rvalid: instr<=mem_rdata, instr_pc<=pc, pc<=pc+4 (mod 2^XLEN), instr_valid<=1; go to HOLD.
- **HOLD:** instr_valid=1 and the outputs stay stable.
  - On instr_ready: the handshake completes, fetch_count+1, instr_valid<=0; go to REQ.
- **DRAIN:** wait for mem_rvalid and discard the data; go to REQ.
- **Redirect:** redir_valid has priority over every other event. pc<=redir_pc and instr_valid<=0. Next state by current state:
  - IDLE: REQ.
  - REQ: DRAIN, because the request just issued is stale.
  - WAIT without mem_rvalid: DRAIN.
  - WAIT with mem_rvalid: the response is discarded; go to REQ.
  - HOLD: REQ. If instr_ready is also high, the handshake still completes and is counted.
  - DRAIN: stay in DRAIN; the new pc is kept.
- mem_rvalid in IDLE, REQ or HOLD is a protocol violation and is ignored.
- Decoded fields are combinational slices of `instr`.
- fetch_count wraps modulo 2^XLEN.

## Timing
- **Reset values:** state=IDLE, pc=RESET_PC, mem_raddr=RESET_PC, mem_rreq=0, instr=0, instr_pc=0, instr_valid=0, fetch_count=0, fault=0.
- RST in any state, including mid-read, forces the reset values. A response arriving after reset is not expected; if one arrives it is ignored because the state is IDLE.
- **First request:** mem_rreq is high in the second cycle after RST deasserts.
- **Latency:** with memory latency k, instr_valid rises k+1 cycles after mem_rreq.
- **Peak rate:** one instruction every k+2 cycles when instr_ready is held high.
- **Stall:** instr, instr_pc and instr_valid hold unchanged while instr_ready=0.

## Configuration
- **FETCH_MISALIGN_TRAP_EN defined:**
  - A redirect with redir_pc[1:0]≠0 sets fault=1 (sticky), clears instr_valid and enters FAULT.
  - If that redirect arrives in REQ or WAIT, the outstanding response is still drained first, then the unit enters FAULT.
  - FAULT issues no requests and ignores redirects; only RST exits it.
- **FETCH_MISALIGN_TRAP_EN undefined:** redir_pc[1:0] is forced to 0, and the `fault` port is absent.

## Test plan
- **Reset and sequential fetch:** RESET_PC=0, k=1, instr_ready=1, memory returns addr+0x100. Required:
  - mem_raddr sequence 0, 4, 8.
  - instr_valid every 3 cycles.
  - instr=0x100, 0x104, 0x108.
  - fetch_count=3.
- **Stall:** instr_ready=0 for 5 cycles in HOLD. Required: no mem_rreq; instr and instr_pc stable; fetch_count unchanged until ready.
- **Redirect in WAIT with k=3:** redirect to 0x40 one cycle after mem_rreq. Required:
  - The late response is dropped.
  - The next mem_raddr=0x40.
  - The delivered instr_pc=0x40.
- **Redirect coincident with mem_rvalid, and redirect in HOLD with instr_ready=1:** Required:
  - Coincident case: the response is discarded.
  - HOLD case: fetch_count increments.
  - Both cases: the next request is to the target.
- **Misaligned redirect to 0x42:**
  - With FETCH_MISALIGN_TRAP_EN: fault=1 and no further mem_rreq until RST.
  - Without it: the next mem_raddr=0x40.
- **Wrap:** pc=2^XLEN−4 fetched. Required: the next mem_raddr=0.

Source files
------------

// File: rtl/fetch_unit_rv.sv
// fetch_unit_rv: owns the PC, issues one instruction read at a time, captures the word into an instruction register.
// Latency: instr_valid rises k+1 cycles after mem_rreq for memory latency k; at best one instruction every k+2 cycles.
// Backpressure: instr_ready low holds instr/instr_pc/instr_valid stable and no new read is issued until accepted.
// Optional: FETCH_MISALIGN_TRAP_EN adds a sticky fault output and a FAULT state for misaligned redirects.
module fetch_unit_rv #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            mem_rreq,
    output logic [XLEN-1:0] mem_raddr,
    input  logic            mem_rvalid,
    input  logic [ILEN-1:0] mem_rdata,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] fetch_count
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fault
`endif
);

    // The reset PC has to be a legal instruction address.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_unit_rv: RESET_PC must be 4-byte aligned");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_FAULT = 3'd5
`endif
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic            capture;
    logic            valid_nxt;
    logic            count_inc;
    logic            redir_take;
    logic            owed;
    logic [XLEN-1:0] redir_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            redir_bad;
    logic            fault_set;

    // Once faulted (even while still draining the last read) redirects are ignored.
    assign redir_take = redir_valid && !fault;
    assign redir_bad  = (redir_pc[1:0] != 2'b00);
    assign redir_tgt  = redir_pc;
`else
    // Without the trap the low address bits are simply dropped.
    assign redir_take = redir_valid;
    assign redir_tgt  = redir_pc & ~XLEN'(3);
`endif

    // A read is still owed by memory when it was just issued, or is in flight and not answering this cycle.
    assign owed = (state == ST_REQ) ||
                  (((state == ST_WAIT) || (state == ST_DRAIN)) && !mem_rvalid);

    // Next-state and datapath controls; a redirect overrides whatever the state itself would do.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        valid_nxt = instr_valid;
        count_inc = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_set = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    capture   = 1'b1;
                    pc_nxt    = pc + XLEN'(4);
                    valid_nxt = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    count_inc = 1'b1;
                    valid_nxt = 1'b0;
                    state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_nxt = fault ? ST_FAULT : ST_REQ;
`else
                    state_nxt = ST_REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Redirect: drop any response in flight or being returned; a HOLD handshake still counts.
        // In DRAIN a response arriving with the redirect retires the stale read, so the new PC is fetched next.
        if (redir_take) begin
            capture   = 1'b0;
            valid_nxt = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redir_bad) begin
                fault_set = 1'b1;
                pc_nxt    = pc;
                state_nxt = owed ? ST_DRAIN : ST_FAULT;
            end else
`endif
            begin
                pc_nxt    = redir_tgt;
                state_nxt = owed ? ST_DRAIN : ST_REQ;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PC, instruction register and accepted-instruction counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc          <= pc_nxt;
            instr_valid <= valid_nxt;
            if (capture) begin
                instr    <= mem_rdata;
                instr_pc <= pc;
            end
            if (count_inc) begin
                fetch_count <= fetch_count + XLEN'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky misaligned-redirect flag; only reset clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fault <= 1'b0;
        end else if (fault_set) begin
            fault <= 1'b1;
        end
    end
`endif

    assign mem_rreq  = (state == ST_REQ);
    assign mem_raddr = pc;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

endmodule

// File: tb/tb_fetch_unit_rv.sv
// tb_fetch_unit_rv: directed, table-driven bench for fetch_unit_rv with a fixed-latency memory responder.
// Latency: memory answers each request k cycles after the request cycle.
// Backpressure: instr_ready is driven directly by the stimulus.
module tb_fetch_unit_rv;
    localparam int XLEN = 64;
    localparam int ILEN = 32;

    logic            CLK;
    logic            RST;
    logic            mem_rreq;
    logic [XLEN-1:0] mem_raddr;
    logic            mem_rvalid;
    logic [ILEN-1:0] mem_rdata;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fault;
`endif

    fetch_unit_rv #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(64'h0)) dut (
        .CLK(CLK), .RST(RST),
        .mem_rreq(mem_rreq), .mem_raddr(mem_raddr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .fetch_count(fetch_count)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .fault(fault)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          k = 1;
    bit          pend = 0;
    int          due = 0;
    logic [63:0] pend_addr = '0;
    bit          fixed_en = 0;
    logic [31:0] fixed_dat = '0;
    int          rreq_cnt = 0;

    typedef struct {
        logic        rdy;
        logic        rreq;
        logic [63:0] raddr;
        logic        iv;
        logic [31:0] ins;
        logic [63:0] ipc;
        logic [63:0] fc;
    } vec_t;

    vec_t vecs[19];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample just after the edge, then model memory for the new cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (mem_rreq === 1'b1) begin
            rreq_cnt++;
            pend      = 1'b1;
            due       = cyc + k;
            pend_addr = mem_raddr;
        end
        if (pend && (due == cyc)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = fixed_en ? fixed_dat : (pend_addr[31:0] + 32'h100);
            pend       = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    endtask

    // Leaves the bench in the first cycle with RST low (DUT in IDLE).
    task automatic do_reset();
        RST         = 1'b1;
        redir_valid = 1'b0;
        instr_ready = 1'b0;
        tick();
        pend       = 1'b0;
        mem_rvalid = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_rreq(input int budget, output bit iv_seen);
        int n = 0;
        iv_seen = 1'b0;
        while (mem_rreq !== 1'b1 && n < budget) begin
            tick();
            if (instr_valid === 1'b1) iv_seen = 1'b1;
            n++;
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (instr_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  c0;
        int  rc0;
        bit  iv_seen;

        //               rdy   rreq  raddr   iv    instr       ipc     fc
        vecs[0]  = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,     64'h0,  64'd0};
        vecs[1]  = '{1'b1, 1'b1, 64'h0,  1'b0, 32'h0,     64'h0,  64'd0};
        vecs[2]  = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,     64'h0,  64'd0};
        vecs[3]  = '{1'b1, 1'b0, 64'h4,  1'b1, 32'h100,   64'h0,  64'd0};
        vecs[4]  = '{1'b1, 1'b1, 64'h4,  1'b0, 32'h100,   64'h0,  64'd1};
        vecs[5]  = '{1'b1, 1'b0, 64'h4,  1'b0, 32'h100,   64'h0,  64'd1};
        vecs[6]  = '{1'b1, 1'b0, 64'h8,  1'b1, 32'h104,   64'h4,  64'd1};
        vecs[7]  = '{1'b1, 1'b1, 64'h8,  1'b0, 32'h104,   64'h4,  64'd2};
        vecs[8]  = '{1'b1, 1'b0, 64'h8,  1'b0, 32'h104,   64'h4,  64'd2};
        vecs[9]  = '{1'b1, 1'b0, 64'hC,  1'b1, 32'h108,   64'h8,  64'd2};
        vecs[10] = '{1'b1, 1'b1, 64'hC,  1'b0, 32'h108,   64'h8,  64'd3};
        vecs[11] = '{1'b1, 1'b0, 64'hC,  1'b0, 32'h108,   64'h8,  64'd3};
        vecs[12] = '{1'b0, 1'b0, 64'h10, 1'b1, 32'h10C,   64'hC,  64'd3};
        vecs[13] = '{1'b0, 1'b0, 64'h10, 1'b1, 32'h10C,   64'hC,  64'd3};
        vecs[14] = '{1'b0, 1'b0, 64'h10, 1'b1, 32'h10C,   64'hC,  64'd3};
        vecs[15] = '{1'b0, 1'b0, 64'h10, 1'b1, 32'h10C,   64'hC,  64'd3};
        vecs[16] = '{1'b0, 1'b0, 64'h10, 1'b1, 32'h10C,   64'hC,  64'd3};
        vecs[17] = '{1'b1, 1'b0, 64'h10, 1'b1, 32'h10C,   64'hC,  64'd3};
        vecs[18] = '{1'b0, 1'b1, 64'h10, 1'b0, 32'h10C,   64'hC,  64'd4};

        RST         = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = '0;
        instr_ready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;

        // Sequential fetch with k=1, then a 5-cycle stall in HOLD.
        k = 1;
        do_reset();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_fault", fault, 0);
`endif
        for (int i = 0; i < 19; i++) begin
            instr_ready = vecs[i].rdy;
            chk($sformatf("v%0d_rreq", i),   mem_rreq,    vecs[i].rreq);
            chk($sformatf("v%0d_raddr", i),  mem_raddr,   vecs[i].raddr);
            chk($sformatf("v%0d_ivalid", i), instr_valid, vecs[i].iv);
            chk($sformatf("v%0d_instr", i),  instr,       vecs[i].ins);
            chk($sformatf("v%0d_ipc", i),    instr_pc,    vecs[i].ipc);
            chk($sformatf("v%0d_fcount", i), fetch_count, vecs[i].fc);
            chk($sformatf("v%0d_rd", i),     rd,          vecs[i].ins[11:7]);
            tick();
        end

        // Reset while a read is outstanding restores every reset value.
        do_reset();
        chk("midrst_rreq", mem_rreq, 0);
        chk("midrst_raddr", mem_raddr, 64'h0);
        chk("midrst_ivalid", instr_valid, 0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_ipc", instr_pc, 64'h0);
        chk("midrst_fcount", fetch_count, 64'd0);

        // Redirect one cycle after the request with k=3: late response dropped.
        k  = 3;
        c0 = cyc;
        tick();
        chk("rw_first_rreq", mem_rreq, 1);
        tick();
        redir_valid = 1'b1;
        redir_pc    = 64'h40;
        tick();
        redir_valid = 1'b0;
        chk("rw_drain_rreq", mem_rreq, 0);
        chk("rw_drain_raddr", mem_raddr, 64'h40);
        wait_rreq(20, iv_seen);
        chk("rw_rreq_seen", mem_rreq, 1);
        chk("rw_req_cycle", cyc - c0, 5);
        chk("rw_raddr", mem_raddr, 64'h40);
        chk("rw_no_stale_valid", iv_seen, 0);
        wait_valid(20);
        chk("rw_ivalid", instr_valid, 1);
        chk("rw_ipc", instr_pc, 64'h40);
        chk("rw_instr", instr, 32'h140);

        // Redirect coincident with the response, k=2, decodable data word.
        do_reset();
        k         = 2;
        fixed_en  = 1'b1;
        fixed_dat = 32'h00C5_82B3;
        tick();
        tick();
        tick();
        redir_valid = 1'b1;
        redir_pc    = 64'h80;
        tick();
        redir_valid = 1'b0;
        chk("co_rreq", mem_rreq, 1);
        chk("co_raddr", mem_raddr, 64'h80);
        chk("co_ivalid", instr_valid, 0);
        chk("co_instr_discarded", instr, 32'h0);
        wait_valid(20);
        chk("co_ivalid_later", instr_valid, 1);
        chk("co_instr", instr, 32'h00C5_82B3);
        chk("co_ipc", instr_pc, 64'h80);
        chk("co_opcode", opcode, 7'h33);
        chk("co_rd", rd, 5'd5);
        chk("co_rs1", rs1, 5'd11);
        chk("co_rs2", rs2, 5'd12);
        chk("co_raddr_next", mem_raddr, 64'h84);

        // Redirect in HOLD together with instr_ready: handshake counted.
        instr_ready = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 64'h200;
        tick();
        instr_ready = 1'b0;
        redir_valid = 1'b0;
        chk("hold_fcount", fetch_count, 64'd1);
        chk("hold_rreq", mem_rreq, 1);
        chk("hold_raddr", mem_raddr, 64'h200);
        chk("hold_ivalid", instr_valid, 0);
        fixed_en = 1'b0;

        // Misaligned redirect to 0x42 issued while waiting on a read.
        do_reset();
        k = 2;
        tick();
        tick();
        redir_valid = 1'b1;
        redir_pc    = 64'h42;
        tick();
        redir_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", fault, 1);
        chk("mis_ivalid", instr_valid, 0);
        rc0 = rreq_cnt;
        repeat (4) tick();
        redir_valid = 1'b1;
        redir_pc    = 64'h100;
        tick();
        redir_valid = 1'b0;
        repeat (8) tick();
        chk("mis_no_rreq", rreq_cnt - rc0, 0);
        chk("mis_fault_sticky", fault, 1);
        do_reset();
        chk("mis_fault_cleared", fault, 0);
`else
        chk("mis_drain_rreq", mem_rreq, 0);
        chk("mis_drain_raddr", mem_raddr, 64'h40);
        rc0 = rreq_cnt;
        tick();
        chk("mis_rreq", mem_rreq, 1);
        chk("mis_raddr", mem_raddr, 64'h40);
        chk("mis_one_req", rreq_cnt - rc0, 1);
`endif

        // PC wrap: fetch at 2^64-4, next address is 0.
        do_reset();
        k           = 1;
        redir_valid = 1'b1;
        redir_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        chk("wrap_rreq", mem_rreq, 1);
        chk("wrap_raddr", mem_raddr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_valid(20);
        chk("wrap_ivalid", instr_valid, 1);
        chk("wrap_instr", instr, 32'h0000_00FC);
        chk("wrap_ipc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc_next", mem_raddr, 64'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap_rreq_next", mem_rreq, 1);
        chk("wrap_raddr_next", mem_raddr, 64'h0);
        chk("wrap_fcount", fetch_count, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
